calculator_alu: RTL and testbench

//  Multi-cycle integer ALU: responder end of the core's ALU request/result handshakes.

---
 rtl/calculator_alu.sv | 165 ++++++++++++++++
 tb/tb_calculator_alu.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/calculator_alu.sv
`default_nettype none
// ============================================================================
// Module   : calculator_alu
// Brief    : Multi-cycle integer ALU (ADD/SUB single-pass, iterative MUL/DIV)
//            with request/result valid-ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module calculator_alu #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] i_alu_input_a,
   input  logic [DATA_WIDTH-1:0] i_alu_input_b,
   input  logic [1:0]            i_alu_input_op,
   input  logic                  i_alu_input_signed,
   input  logic                  i_alu_input_valid,
   output logic                  o_alu_input_ready,
   output logic [DATA_WIDTH-1:0] o_alu_result,
   output logic                  o_alu_error,
   output logic                  o_alu_result_valid,
   input  logic                  i_alu_result_ready
);
   localparam int W = DATA_WIDTH;
   localparam int c_CNT_W = $clog2(W) + 1;
   localparam logic [c_CNT_W-1:0] c_ITERS = c_CNT_W'(W);
   localparam logic [1:0] c_OP_ADD = 2'b00;
   localparam logic [1:0] c_OP_SUB = 2'b01;
   localparam logic [1:0] c_OP_MUL = 2'b10;
   localparam logic [W-1:0]   c_HALF  = {1'b1, {(W-1){1'b0}}};
   localparam logic [2*W-1:0] c_HALF2 = {{W{1'b0}}, c_HALF};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state, w_state_nxt;

   logic [W-1:0]       r_a, r_b, r_divisor, r_shift, r_rem, r_result;
   logic [1:0]         r_op;
   logic               r_signed, r_fast, r_neg, r_error;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2*W-1:0]     r_acc, r_mcand;

   logic           w_accept, w_calc_done;
   logic [W-1:0]   w_abs_a, w_abs_b, w_fin_value, w_fin_result;
   logic           w_fin_error;
   logic [W:0]     w_sum, w_dif, w_rem_sh, w_rem_diff;
   logic           w_add_ovf, w_sub_ovf;

   assign o_alu_input_ready  = (r_state == S_IDLE) && !rst;
   assign o_alu_result_valid = (r_state == S_DONE);
   assign o_alu_result       = r_result;
   assign o_alu_error        = r_error;

   assign w_accept    = i_alu_input_valid && o_alu_input_ready;
   assign w_calc_done = r_fast || (r_cnt == c_ITERS);

   assign w_abs_a = (i_alu_input_signed && i_alu_input_a[W-1]) ? -i_alu_input_a : i_alu_input_a;
   assign w_abs_b = (i_alu_input_signed && i_alu_input_b[W-1]) ? -i_alu_input_b : i_alu_input_b;

   assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
   assign w_dif     = {1'b0, r_a} - {1'b0, r_b};
   assign w_add_ovf = (r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]);
   assign w_sub_ovf = (r_a[W-1] != r_b[W-1]) && (w_dif[W-1] != r_a[W-1]);

   // Restoring division step: bit W of the trial difference is the borrow.
   assign w_rem_sh   = {r_rem, r_shift[W-1]};
   assign w_rem_diff = w_rem_sh - {1'b0, r_divisor};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)           w_state_nxt = S_CALC;
         S_CALC:  if (w_calc_done)        w_state_nxt = S_DONE;
         S_DONE:  if (i_alu_result_ready) w_state_nxt = S_IDLE;
         default:                         w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_fin_value = '0;
      w_fin_error = 1'b0;
      case (r_op)
         c_OP_ADD: begin
            w_fin_value = w_sum[W-1:0];
            w_fin_error = r_signed ? w_add_ovf : w_sum[W];
         end
         c_OP_SUB: begin
            w_fin_value = w_dif[W-1:0];
            w_fin_error = r_signed ? w_sub_ovf : w_dif[W];
         end
         c_OP_MUL: begin
            w_fin_value = r_neg ? -r_acc[W-1:0] : r_acc[W-1:0];
            if (r_signed) w_fin_error = r_neg ? (r_acc > c_HALF2) : (r_acc >= c_HALF2);
            else          w_fin_error = |r_acc[2*W-1:W];
         end
         default: begin
            w_fin_value = r_neg ? -r_shift : r_shift;
            // Only -2^(W-1) / -1 yields a positive quotient of 2^(W-1).
            w_fin_error = (r_b == '0) || (r_signed && !r_neg && (r_shift >= c_HALF));
         end
      endcase
      w_fin_result = w_fin_error ? '0 : w_fin_value;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= '0;
         r_signed  <= 1'b0;
         r_fast    <= 1'b0;
         r_neg     <= 1'b0;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_divisor <= '0;
         r_shift   <= '0;
         r_rem     <= '0;
         r_result  <= '0;
         r_error   <= 1'b0;
      end else if (w_accept) begin
         r_a       <= i_alu_input_a;
         r_b       <= i_alu_input_b;
         r_op      <= i_alu_input_op;
         r_signed  <= i_alu_input_signed;
         r_fast    <= (i_alu_input_op == c_OP_ADD) || (i_alu_input_op == c_OP_SUB) ||
                      (i_alu_input_b == '0);
         r_neg     <= i_alu_input_signed && (i_alu_input_a[W-1] ^ i_alu_input_b[W-1]);
         r_cnt     <= '0;
         r_acc     <= '0;
         r_rem     <= '0;
         r_mcand   <= {{W{1'b0}}, w_abs_a};
         r_divisor <= w_abs_b;
         r_shift   <= (i_alu_input_op == c_OP_MUL) ? w_abs_b : w_abs_a;
      end else if (r_state == S_CALC) begin
         if (!w_calc_done) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op == c_OP_MUL) begin
               if (r_shift[0]) r_acc <= r_acc + r_mcand;
               r_mcand <= r_mcand << 1;
               r_shift <= r_shift >> 1;
            end else if (!w_rem_diff[W]) begin
               r_rem   <= w_rem_diff[W-1:0];
               r_shift <= {r_shift[W-2:0], 1'b1};
            end else begin
               r_rem   <= w_rem_sh[W-1:0];
               r_shift <= {r_shift[W-2:0], 1'b0};
            end
         end else begin
            r_result <= w_fin_result;
            r_error  <= w_fin_error;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_calculator_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_calculator_alu
// Brief    : Directed self-checking bench for calculator_alu (W=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_calculator_alu;
   localparam int W = 16;
   localparam logic [1:0] c_ADD = 2'b00, c_SUB = 2'b01, c_MUL = 2'b10, c_DIV = 2'b11;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] i_a = '0, i_b = '0;
   logic [1:0]   i_op = '0;
   logic         i_sgn = 1'b0, i_valid = 1'b0, i_rready = 1'b0;
   logic         o_ready, o_err, o_rvalid;
   logic [W-1:0] o_res;

   int checks = 0;
   int errors = 0;

   calculator_alu #(.DATA_WIDTH(W)) dut (
      .clk                (clk),
      .rst                (rst),
      .i_alu_input_a      (i_a),
      .i_alu_input_b      (i_b),
      .i_alu_input_op     (i_op),
      .i_alu_input_signed (i_sgn),
      .i_alu_input_valid  (i_valid),
      .o_alu_input_ready  (o_ready),
      .o_alu_result       (o_res),
      .o_alu_error        (o_err),
      .o_alu_result_valid (o_rvalid),
      .i_alu_result_ready (i_rready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op, input logic sgn);
      int n = 0;
      @(negedge clk);
      while (!o_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      i_a = a; i_b = b; i_op = op; i_sgn = sgn; i_valid = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!o_rvalid && lat < 60);
   endtask

   task automatic handshake();
      @(negedge clk) i_rready = 1'b1;
      @(posedge clk);
      #1 i_rready = 1'b0;
   endtask

   task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, input logic sgn,
                      input logic [W-1:0] exp_res, input logic exp_err, input int exp_lat);
      int lat;
      start_op(a, b, op, sgn);
      wait_result(lat);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_res"}, 32'(o_res), 32'(exp_res));
      chk({tag, "_err"}, 32'(o_err), 32'(exp_err));
      handshake();
   endtask

   initial begin
      int lat;
      logic seen;

      #2;
      chk("rst_ready",  32'(o_ready),  32'd0);
      chk("rst_valid",  32'(o_rvalid), 32'd0);
      chk("rst_result", 32'(o_res),    32'd0);
      chk("rst_error",  32'(o_err),    32'd0);
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      #1 chk("post_rst_ready", 32'(o_ready), 32'd1);

      run("add_u",     16'h1234, 16'h0001, c_ADD, 1'b0, 16'h1235, 1'b0, 1);
      run("add_u_cy",  16'hFFFF, 16'h0001, c_ADD, 1'b0, 16'h0000, 1'b1, 1);
      run("add_s_ovf", 16'h7FFF, 16'h0001, c_ADD, 1'b1, 16'h0000, 1'b1, 1);
      run("add_s_neg", 16'hFFFF, 16'hFFFE, c_ADD, 1'b1, 16'hFFFD, 1'b0, 1);
      run("sub_s_ovf", 16'h8000, 16'h0001, c_SUB, 1'b1, 16'h0000, 1'b1, 1);
      run("sub_u_brw", 16'h0005, 16'h0007, c_SUB, 1'b0, 16'h0000, 1'b1, 1);
      run("sub_s",     16'h0005, 16'h0007, c_SUB, 1'b1, 16'hFFFE, 1'b0, 1);
      run("mul_s",     16'hFFFD, 16'h0007, c_MUL, 1'b1, 16'hFFEB, 1'b0, 17);
      run("mul_u_ovf", 16'h0100, 16'h0100, c_MUL, 1'b0, 16'h0000, 1'b1, 17);
      run("mul_u_max", 16'h00FF, 16'h0101, c_MUL, 1'b0, 16'hFFFF, 1'b0, 17);
      run("mul_s_min", 16'h0100, 16'hFF80, c_MUL, 1'b1, 16'h8000, 1'b0, 17);
      run("mul_s_ovf", 16'h0080, 16'h0100, c_MUL, 1'b1, 16'h0000, 1'b1, 17);
      run("div_s",     16'hFFF9, 16'h0002, c_DIV, 1'b1, 16'hFFFD, 1'b0, 17);
      run("div_u",     16'd100,  16'd7,    c_DIV, 1'b0, 16'd14,   1'b0, 17);
      run("div_zero",  16'h1234, 16'h0000, c_DIV, 1'b0, 16'h0000, 1'b1, 1);
      run("div_s_ovf", 16'h8000, 16'hFFFF, c_DIV, 1'b1, 16'h0000, 1'b1, 17);
      run("div_u_big", 16'h8000, 16'hFFFF, c_DIV, 1'b0, 16'h0000, 1'b0, 17);
      run("div_s_min", 16'h8000, 16'h0001, c_DIV, 1'b1, 16'h8000, 1'b0, 17);

      // Result back-pressure: DONE must hold everything and refuse new requests.
      start_op(16'd3, 16'd4, c_MUL, 1'b0);
      wait_result(lat);
      chk("hold_lat", 32'(lat), 32'd17);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         i_a = 16'h0009; i_b = 16'h0009; i_op = c_ADD; i_valid = 1'b1;
         @(posedge clk);
         #1;
         chk("hold_res",   32'(o_res),    32'h000C);
         chk("hold_err",   32'(o_err),    32'd0);
         chk("hold_valid", 32'(o_rvalid), 32'd1);
         chk("hold_ready", 32'(o_ready),  32'd0);
      end
      @(negedge clk) i_valid = 1'b0;
      handshake();
      chk("hs_valid", 32'(o_rvalid), 32'd0);
      chk("hs_ready", 32'(o_ready),  32'd1);
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1 if (o_rvalid) seen = 1'b1;
      end
      chk("hs_no_stray", 32'(seen), 32'd0);

      // Reset in the middle of an iterative multiply.
      start_op(16'h1234, 16'h0002, c_MUL, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      #1;
      chk("mid_rst_ready",  32'(o_ready),  32'd0);
      chk("mid_rst_valid",  32'(o_rvalid), 32'd0);
      chk("mid_rst_result", 32'(o_res),    32'd0);
      chk("mid_rst_error",  32'(o_err),    32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk("rel_ready", 32'(o_ready), 32'd1);
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1 if (o_rvalid) seen = 1'b1;
      end
      chk("rel_no_result", 32'(seen), 32'd0);
      run("add_after_rst", 16'd2, 16'd3, c_ADD, 1'b0, 16'd5, 1'b0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
